// File: rtl/ssd_pkg.sv
// Shared definitions for the score display: segment encoding, digit limits and
// the state type of the sequential binary-to-BCD converter.
package ssd_pkg;

    localparam int         MAX_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } b2b_state_t;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes show nothing.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/score_ssd_driver_bin2bcd_seq.sv
// Sequential double-dabble converter with a 1-deep pending load; the visible
// digit register only updates at the end of a conversion.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int SCORE_W    = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SCORE_W-1:0]      i_score,
    input  logic                    i_load,
    output logic                    o_busy,
    output logic                    o_ovf,
    output logic [NUM_DIGITS*4-1:0] o_digits
);

    localparam int                  BCD_W     = NUM_DIGITS * 4;
    localparam int                  CNT_W     = $clog2(SCORE_W);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SCORE_W - 1);
    localparam logic [BCD_W-1:0]    ALL_NINES = {NUM_DIGITS{4'd9}};
    localparam longint unsigned     LIMIT     = pow10(NUM_DIGITS);
    localparam longint unsigned     SCORE_MAX = (64'd1 << SCORE_W) - 64'd1;
    // A limit beyond the score range saturates so the compare can never fire.
    localparam logic [SCORE_W+3:0]  OVF_LIMIT = (LIMIT > SCORE_MAX) ?
                                                {(SCORE_W+4){1'b1}} : (SCORE_W+4)'(LIMIT);

    b2b_state_t          r_state;
    b2b_state_t          w_state_next;
    logic [SCORE_W-1:0]  r_bin;
    logic [SCORE_W-1:0]  r_pend_val;
    logic                r_pend_valid;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    r_digits;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf_cur;
    logic                r_ovf;
    logic                w_start;
    logic [SCORE_W-1:0]  w_start_val;
    logic                w_start_ovf;
    logic [BCD_W-1:0]    w_bcd_adj;
    logic [BCD_W-1:0]    w_bcd_shift;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_start_val  = i_score;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_state_next = ST_SHIFT;
                    w_start      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A load landing on DONE is the newest pending value and wins.
                if (i_load || r_pend_valid) begin
                    w_state_next = ST_SHIFT;
                    w_start      = 1'b1;
                    if (!i_load) begin
                        w_start_val = r_pend_val;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_start_ovf = {4'b0000, w_start_val} >= OVF_LIMIT;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[SCORE_W-1]};

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the digit register is reset because the display must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_ovf_cur    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_val   <= '0;
            r_digits     <= '0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_start) begin
                r_bin     <= w_start_val;
                r_bcd     <= '0;
                r_cnt     <= '0;
                r_ovf_cur <= w_start_ovf;
            end else if (r_state == ST_SHIFT) begin
                r_bin <= r_bin << 1;
                r_bcd <= w_bcd_shift;
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == ST_DONE) begin
                r_digits     <= r_ovf_cur ? ALL_NINES : r_bcd;
                r_ovf        <= r_ovf_cur;
                r_pend_valid <= 1'b0;
            end else if (r_state == ST_SHIFT && i_load) begin
                r_pend_valid <= 1'b1;
                r_pend_val   <= i_score;
            end
        end
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_ovf    = r_ovf;
    assign o_digits = r_digits;

endmodule

// File: rtl/score_ssd_driver.sv
// Score display top: BCD conversion plus multiplexed seven-segment scan.
// Optional macro SSD_LZ_BLANK_EN blanks leading-zero digits above the top nonzero one.
module score_ssd_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCORE_W    = 16,
    parameter int SCAN_DIV_W = 18,
    parameter int BLANK_CYC  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_load,
    output logic               busy,
    output logic               ovf,
    output logic [7:0]         an,
    output logic [6:0]         seg,
    output logic               dp
);

    localparam logic [SCAN_DIV_W-1:0] BLANK_L  = SCAN_DIV_W'(BLANK_CYC);
    localparam logic [2:0]            IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [NUM_DIGITS*4-1:0] w_digits;
    logic [MAX_DIGITS*4-1:0] w_digits_pad;
    logic [SCAN_DIV_W-1:0]   r_presc;
    logic [2:0]              r_idx;
    logic [7:0]              r_an;
    logic [6:0]              r_seg;
    logic [3:0]              w_digit;
    logic                    w_digit_blank;
    logic [7:0]              w_an_next;
    logic [6:0]              w_seg_next;

    bin2bcd_seq #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk      (clk),
        .rst      (rst),
        .i_score  (score_in),
        .i_load   (score_load),
        .o_busy   (busy),
        .o_ovf    (ovf),
        .o_digits (w_digits)
    );

    assign w_digits_pad = (MAX_DIGITS*4)'(w_digits);
    assign w_digit      = w_digits_pad[{r_idx, 2'b00} +: 4];

`ifdef SSD_LZ_BLANK_EN
    logic [2:0] w_msnz;

    // Digit 0 is never blanked, so an all-zero score still shows "0".
    always_comb begin
        w_msnz = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (w_digits_pad[i*4 +: 4] != 4'd0) begin
                w_msnz = 3'(i);
            end
        end
    end

    assign w_digit_blank = (r_idx > w_msnz);
`else
    assign w_digit_blank = 1'b0;
`endif

    always_comb begin
        w_an_next  = 8'hFF;
        w_seg_next = SEG_BLANK;
        if (r_presc >= BLANK_L) begin
            w_an_next = ~(8'h01 << r_idx);
            if (!w_digit_blank) begin
                w_seg_next = bcd_to_seg(w_digit);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
            r_an    <= 8'hFF;
            r_seg   <= SEG_BLANK;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (&r_presc) begin
                r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_score_ssd_driver.sv
// Directed bench for score_ssd_driver: scoreboard on the committed digit register,
// scan pattern checks on an/seg, pending-load and async-reset scenarios.
module tb_score_ssd_driver;

    localparam int NUM_DIGITS = 4;
    localparam int SCORE_W    = 16;
    localparam int SCAN_DIV_W = 4;
    localparam int BLANK_CYC  = 2;
    localparam int SLOT       = 1 << SCAN_DIV_W;

    typedef struct packed {
        logic [15:0] digits;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] score_in;
    logic        score_load;
    logic        busy;
    logic        ovf;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    exp_t        sb_q[$];
    exp_t        last_obs;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc;

    score_ssd_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCORE_W    (SCORE_W),
        .SCAN_DIV_W (SCAN_DIV_W),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .score_in   (score_in),
        .score_load (score_load),
        .busy       (busy),
        .ovf        (ovf),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; scan position is derived from this.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every change of the committed digits/ovf must match the next queued result.
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = {dut.w_digits, ovf};
        if (rst) begin
            last_obs = cur;
        end else if (cur !== last_obs) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 32'(cur), 32'(last_obs));
            end else begin
                e = sb_q.pop_front();
                check("sb_display", 32'(cur), 32'(e));
            end
            last_obs = cur;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] scan_seg(input logic [15:0] digs, input int idx);
`ifdef SSD_LZ_BLANK_EN
        int top;
        top = 0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (digs[i*4 +: 4] != 4'd0) top = i;
        end
        if (idx > top) return 7'h7F;
`endif
        return seg_of(digs[idx*4 +: 4]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        score_in   = v;
        score_load = 1'b1;
        tick();
        score_load = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic check_scan(input logic [15:0] digs, input int ncyc);
        int         p;
        int         idx;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            p   = int'((cyc - 1) % SLOT);
            idx = int'(((cyc - 1) / SLOT) % NUM_DIGITS);
            if (p < BLANK_CYC) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(8'h01 << idx);
                exp_seg = scan_seg(digs, idx);
            end
            check("scan_an", 32'(an), 32'(exp_an));
            check("scan_seg", 32'(seg), 32'(exp_seg));
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        score_load = 1'b0;
        score_in   = '0;
        tick();
        tick();
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_digits", 32'(dut.w_digits), 32'h0);
        rst = 1'b0;
        check_scan(16'h0000, 4 * SLOT + 4);

        // Single conversion: busy for 17 cycles, digits commit on the 18th edge.
        sb_q.push_back('{digits: 16'h1234, ovf: 1'b0});
        load(16'd1234);
        check("busy_rise", 32'(busy), 32'h1);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("busy_shift", 32'(busy), 32'h1);
        end
        tick();
        check("busy_fall", 32'(busy), 32'h0);
        check("ovf_1234", 32'(ovf), 32'h0);
        check_scan(16'h1234, 4 * SLOT);

        // Pending overwrite: 7 is replaced by 42 before it ever starts.
        sb_q.push_back('{digits: 16'h0100, ovf: 1'b0});
        sb_q.push_back('{digits: 16'h0042, ovf: 1'b0});
        load(16'd100);
        tick();
        tick();
        load(16'd7);
        tick();
        tick();
        load(16'd42);
        wait_idle(n);
        check("b2b_latency", 32'(n), 32'd28);

        // Load arriving exactly on DONE chains straight into a new conversion.
        sb_q.push_back('{digits: 16'h0321, ovf: 1'b0});
        sb_q.push_back('{digits: 16'h0654, ovf: 1'b0});
        load(16'd321);
        repeat (16) tick();
        load(16'd654);
        check("done_load_busy", 32'(busy), 32'h1);
        wait_idle(n);
        check("done_load_latency", 32'(n), 32'd17);

        // Overflow boundary: 9999 is exact, 10000 saturates, 5 clears ovf.
        sb_q.push_back('{digits: 16'h9999, ovf: 1'b0});
        load(16'd9999);
        wait_idle(n);
        check("lat_9999", 32'(n), 32'd17);
        check("ovf_9999", 32'(ovf), 32'h0);
        sb_q.push_back('{digits: 16'h9999, ovf: 1'b1});
        load(16'd10000);
        wait_idle(n);
        check("lat_10000", 32'(n), 32'd17);
        check("ovf_10000", 32'(ovf), 32'h1);
        sb_q.push_back('{digits: 16'h0005, ovf: 1'b0});
        load(16'd5);
        wait_idle(n);
        check("ovf_5", 32'(ovf), 32'h0);
        check_scan(16'h0005, 4 * SLOT);

        // Async reset mid-conversion: outputs drop immediately, 777 never commits.
        load(16'd777);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_an", 32'(an), 32'hFF);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ovf", 32'(ovf), 32'h0);
        check("arst_dp", 32'(dp), 32'h1);
        tick();
        rst = 1'b0;
        check_scan(16'h0000, 2 * SLOT);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_digits", 32'(dut.w_digits), 32'h0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
